dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
- Direct-mapped, read-only cache controller and line store. Sits directly upstream of the 32K-word data memory (dataMem) and in front of the requester (CPU/testbench).
- On a hit, serves one 32-bit word from the internal line array. On a miss, presents the block address to dataMem, models a configurable miss penalty, fills the whole 4-word line, then responds.
- Keeps access and hit counters for hit-rate measurement.

Parameters:
- ADDR_W, 15, word address width (matches the dataMem address).
- INDEX_W, 10, line index bits; 1024 lines of 4 words each. Tag width is ADDR_W-INDEX_W-2 = 3.
- MISS_LATENCY, 4, cycles spent in MISS_WAIT before the fill; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  requester presents an address.
- req_address  in  15  word address.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- resp_valid  out  1  one-cycle pulse carrying the read result; no backpressure.
- resp_data  out  32  requested word; valid only while resp_valid is high.
- resp_hit  out  1  1 = hit, 0 = miss; qualified by resp_valid.
- mem_address  out  15  block address to dataMem: {latched_addr[14:2], 2'b00}.
- mem_data  in  32 x [0:3]  unpacked block from dataMem (combinational read).
- access_count  out  32  accepted requests; wraps modulo 2^32.
- hit_count  out  32  hits; wraps modulo 2^32.

Behaviour:
- Address split: offset = addr[1:0], index = addr[11:2], tag = addr[14:12].
- Reset values:
  - All 1024 valid bits cleared in the single reset cycle.
  - State = IDLE, req_ready = 1, resp_valid = 0, resp_data = 0, resp_hit = 0.
  - Both counters = 0; mem_address = 0.
  - Tag and data arrays are not reset.
- States:
  - IDLE: req_ready = 1. On acceptance, latch req_address, increment access_count, go to LOOKUP.
  - LOOKUP: one cycle. Compare the stored tag and valid bit at the latched index. On a hit, increment hit_count, register the data word and resp_hit = 1, go to RESPOND. On a miss, load the wait counter with MISS_LATENCY-1, go to MISS_WAIT.
  - MISS_WAIT: decrement the counter each cycle. When it is 0, go to FILL. Total cycles in MISS_WAIT = MISS_LATENCY.
  - FILL: one cycle. Write mem_data[0..3], the tag and valid = 1 into the line. Register resp_data = mem_data[offset] directly (bypass) and resp_hit = 0. Go to RESPOND.
  - RESPOND: resp_valid = 1 for exactly this cycle, then go to IDLE.
- Latency, counted from the acceptance edge to the resp_valid cycle:
  - Hit: 2 cycles.
  - Miss: 3 + MISS_LATENCY cycles (7 at the default).
- Back-to-back requests: the earliest next acceptance is the cycle after RESPOND. req_valid in any non-IDLE state is ignored.
- mem_address is held at the latched block address from LOOKUP through FILL. It holds its last value in all other states.
- A miss whose index holds a valid line with a different tag overwrites that line (eviction). There is no writeback because the cache is read-only.
- rst asserted in any state, including mid-miss: the in-flight request is abandoned, no response is issued, no fill happens, and all lines are invalidated.
- Counters wrap: 0xFFFFFFFF + 1 = 0. There is no saturation.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W, INDEX_W, TAG_W, OFFSET_W, LINE_WORDS = 4.
  - typedef state_t enum {IDLE, LOOKUP, MISS_WAIT, FILL, RESPOND}.
  - typedef line_t struct {tag, data[0:3]}.
  - Helper functions get_tag, get_index and get_offset.
- One sub-module, cache_line_array, holds the valid flop vector with sync clear, plus the tag/data arrays. It has one read port (index to tag, valid, data) and one write port (we, index, tag, block).
- The FSM and counters stay in dm_cache_ctrl.

Test Plan:
- Cold miss: after reset, request 0x0005 -> resp_valid 7 cycles after acceptance, resp_data = 0x5, resp_hit = 0, mem_address = 0x0004 during MISS_WAIT; counts access = 1, hit = 0.
- Spatial hit: then request 0x0006 -> resp_valid 2 cycles after acceptance, resp_data = 0x6, resp_hit = 1; counts access = 2, hit = 1.
- Conflict eviction: request 0x1004 (same index 1, tag 1) -> miss, data 0x1004. Then 0x0004 -> miss again, data 0x4. Then 0x0004 -> hit.
- Reset mid-miss: accept 0x7FFF, assert rst on the second MISS_WAIT cycle -> no resp_valid ever, req_ready = 1 after reset, counters = 0. A following request to 0x7FFF misses, data 0x7FFF.
- Handshake: hold req_valid high continuously with changing addresses -> exactly one acceptance per transaction, and req_ready stays low from LOOKUP through RESPOND.
- MISS_LATENCY = 1 build: a miss to 0x0100 responds 4 cycles after acceptance with data 0x100.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped read-only cache.
package cache_pkg;

  localparam int ADDR_W     = 15;
  localparam int INDEX_W    = 10;
  localparam int OFFSET_W   = 2;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 1 << INDEX_W;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT,
    FILL,
    RESPOND
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]                       tag;
    logic [0:LINE_WORDS-1][DATA_W-1:0]      data;
  } line_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line store: valid bit vector cleared by reset, tag/data array with one
// asynchronous read port and one synchronous write port.
module cache_line_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output line_t              rd_line_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  line_t              wr_line_i
);

  logic [NUM_LINES-1:0] valid_q;
  line_t                lines_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // NOTE: the tag/data storage has no reset; the valid bits alone decide
  // whether a line is meaningful, which keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      lines_q[wr_index_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_line_o  = lines_q[rd_index_i];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read-only cache controller: request FSM, miss-penalty timer,
// line fill from dataMem and access/hit counters.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int MISS_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_address,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data [0:LINE_WORDS-1],
  output logic [31:0]       access_count,
  output logic [31:0]       hit_count
);

  if (MISS_LATENCY < 1 || MISS_LATENCY > 15) begin : g_bad_latency
    $error("MISS_LATENCY must be within 1..15");
  end

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wait_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_hit_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [31:0]       access_q;
  logic [31:0]       hit_q;

  logic  rd_valid;
  line_t rd_line;
  logic  lookup_hit;
  logic  fill_we;
  line_t fill_line;

  assign lookup_hit = rd_valid && (rd_line.tag == get_tag(addr_q));

  // A reset landing on the FILL edge must not leave a half-installed line behind.
  assign fill_we = (state_q == FILL) && !rst;

  always_comb begin
    fill_line.tag = get_tag(addr_q);
    for (int i = 0; i < LINE_WORDS; i++) begin
      fill_line.data[i] = mem_data[i];
    end
  end

  cache_line_array u_lines (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (get_index(addr_q)),
    .rd_valid_o (rd_valid),
    .rd_line_o  (rd_line),
    .we_i       (fill_we),
    .wr_index_i (get_index(addr_q)),
    .wr_line_i  (fill_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wait_q        <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_hit_q    <= 1'b0;
      mem_address_q <= '0;
      access_q      <= '0;
      hit_q         <= '0;
    end else begin
      // NOTE: resp_valid defaults low every cycle so it can only ever be a
      // single-cycle pulse on entry to RESPOND.
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q        <= req_address;
            mem_address_q <= {req_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            access_q      <= access_q + 32'd1;
            req_ready_q   <= 1'b0;
            state_q       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookup_hit) begin
            hit_q        <= hit_q + 32'd1;
            resp_data_q  <= rd_line.data[get_offset(addr_q)];
            resp_hit_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= RESPOND;
          end else begin
            wait_q  <= 4'(MISS_LATENCY - 1);
            state_q <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q <= FILL;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        FILL: begin
          resp_data_q  <= mem_data[get_offset(addr_q)];
          resp_hit_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESPOND;
        end
        RESPOND: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_hit     = resp_hit_q;
  assign mem_address  = mem_address_q;
  assign access_count = access_q;
  assign hit_count    = hit_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios plus randomized
// traffic scored against a residency model (which block sits at each index).
module tb_dm_cache_ctrl;
  import cache_pkg::*;

  localparam int MISS_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0;
  logic [14:0] req_address = '0;
  logic        req_ready, resp_valid, resp_hit;
  logic [31:0] resp_data, access_count, hit_count;
  logic [14:0] mem_address;
  logic [31:0] mem_data [0:3];

  logic        req_valid1 = 1'b0;
  logic [14:0] req_address1 = '0;
  logic        req_ready1, resp_valid1, resp_hit1;
  logic [31:0] resp_data1, access_count1, hit_count1;
  logic [14:0] mem_address1;
  logic [31:0] mem_data1 [0:3];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which tag is resident at each index, plus expected counts.
  bit          m_valid [1024];
  logic [2:0]  m_tag   [1024];
  logic [31:0] m_acc;
  logic [31:0] m_hit;

  always #5 clk = ~clk;

  // dataMem stand-in: every word holds its own address.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mem_data[i]  = 32'(mem_address)  + 32'(i);
      mem_data1[i] = 32'(mem_address1) + 32'(i);
    end
  end

  dm_cache_ctrl #(.MISS_LATENCY(MISS_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_address  (req_address),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_hit     (resp_hit),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .access_count (access_count),
    .hit_count    (hit_count)
  );

  dm_cache_ctrl #(.MISS_LATENCY(1)) dut_l1 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid1),
    .req_address  (req_address1),
    .req_ready    (req_ready1),
    .resp_valid   (resp_valid1),
    .resp_data    (resp_data1),
    .resp_hit     (resp_hit1),
    .mem_address  (mem_address1),
    .mem_data     (mem_data1),
    .access_count (access_count1),
    .hit_count    (hit_count1)
  );

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    m_acc = '0;
    m_hit = '0;
  endtask

  // One full transaction on the main DUT, starting in an IDLE cycle at a negedge.
  // With noisy set, req_valid stays high with random addresses while busy.
  task automatic do_req(input logic [14:0] addr, input bit noisy);
    int          idx     = int'(addr[11:2]);
    bit          exp_hit = m_valid[idx] && (m_tag[idx] == addr[14:12]);
    int          exp_lat = exp_hit ? 2 : 3 + MISS_LAT;
    logic [14:0] blk     = {addr[14:2], 2'b00};
    int          cycles;
    bit          ok_ready = 1'b1;
    bit          ok_addr  = 1'b1;

    req_valid   = 1'b1;
    req_address = addr;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_idle addr=%h got=%b want=1", addr, req_ready);
    end
    @(negedge clk);
    m_acc = m_acc + 32'd1;
    if (exp_hit) m_hit = m_hit + 32'd1;
    else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = addr[14:12];
    end
    req_valid   = noisy;
    req_address = 15'($urandom);
    cycles = 1;
    while (resp_valid !== 1'b1 && cycles < 40) begin
      if (req_ready !== 1'b0) ok_ready = 1'b0;
      if (mem_address !== blk) ok_addr = 1'b0;
      @(negedge clk);
      cycles++;
      if (noisy) req_address = 15'($urandom);
    end

    n_cmp++;
    if (cycles != exp_lat) begin
      n_bad++;
      $display("FAIL latency addr=%h got=%0d want=%0d", addr, cycles, exp_lat);
    end
    n_cmp++;
    if (resp_data !== {17'd0, addr}) begin
      n_bad++;
      $display("FAIL resp_data addr=%h got=%h want=%h", addr, resp_data, {17'd0, addr});
    end
    n_cmp++;
    if (resp_hit !== exp_hit) begin
      n_bad++;
      $display("FAIL resp_hit addr=%h got=%b want=%b", addr, resp_hit, exp_hit);
    end
    n_cmp++;
    if (access_count !== m_acc || hit_count !== m_hit) begin
      n_bad++;
      $display("FAIL counters addr=%h got=%0d/%0d want=%0d/%0d",
               addr, access_count, hit_count, m_acc, m_hit);
    end
    n_cmp++;
    if (!ok_ready || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_busy addr=%h got=%b want=0 throughout", addr, req_ready);
    end
    n_cmp++;
    if (!ok_addr || mem_address !== blk) begin
      n_bad++;
      $display("FAIL mem_address addr=%h got=%h want=%h", addr, mem_address, blk);
    end

    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL pulse_end addr=%h got valid=%b ready=%b want valid=0 ready=1",
               addr, resp_valid, req_ready);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'd0 || resp_hit !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got ready=%b valid=%b data=%h hit=%b want 1/0/0/0",
               req_ready, resp_valid, resp_data, resp_hit);
    end
    n_cmp++;
    if (access_count !== 32'd0 || hit_count !== 32'd0 || mem_address !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_regs got acc=%0d hit=%0d maddr=%h want 0/0/0",
               access_count, hit_count, mem_address);
    end
    n_cmp++;
    if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_l1 got ready=%b valid=%b want 1/0", req_ready1, resp_valid1);
    end
  endtask

  task automatic test_cold_and_spatial();
    do_req(15'h0005, 1'b0);
    do_req(15'h0006, 1'b0);
  endtask

  task automatic test_conflict();
    do_req(15'h1004, 1'b0);
    do_req(15'h0004, 1'b0);
    do_req(15'h0004, 1'b0);
  endtask

  task automatic test_reset_mid_miss();
    bit saw = 1'b0;
    req_valid   = 1'b1;
    req_address = 15'h7FFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (12) begin
      if (resp_valid !== 1'b0) saw = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw) begin
      n_bad++;
      $display("FAIL abandoned_resp got resp_valid=1 want none");
    end
    n_cmp++;
    if (req_ready !== 1'b1 || access_count !== 32'd0 || hit_count !== 32'd0) begin
      n_bad++;
      $display("FAIL after_reset got ready=%b acc=%0d hit=%0d want 1/0/0",
               req_ready, access_count, hit_count);
    end
    do_req(15'h7FFF, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_req(15'h0020, 1'b1);
    do_req(15'h0021, 1'b1);
    do_req(15'h2022, 1'b1);
    do_req(15'h0023, 1'b1);
  endtask

  task automatic test_random();
    logic [14:0] a;
    for (int i = 0; i < 40; i++) begin
      a = {3'($urandom_range(0, 3)), 8'd0, 2'($urandom_range(0, 3)), 2'($urandom)};
      do_req(a, 1'($urandom));
    end
  endtask

  task automatic test_miss_latency1();
    logic [14:0] addrs [2] = '{15'h0100, 15'h0101};
    int          exp_lat [2] = '{4, 2};
    bit          exp_hit [2] = '{1'b0, 1'b1};
    int          cycles;
    for (int k = 0; k < 2; k++) begin
      req_valid1   = 1'b1;
      req_address1 = addrs[k];
      @(negedge clk);
      req_valid1 = 1'b0;
      cycles = 1;
      while (resp_valid1 !== 1'b1 && cycles < 40) begin
        @(negedge clk);
        cycles++;
      end
      n_cmp++;
      if (cycles != exp_lat[k] || resp_data1 !== {17'd0, addrs[k]} || resp_hit1 !== exp_hit[k]) begin
        n_bad++;
        $display("FAIL l1_access addr=%h got lat=%0d data=%h hit=%b want lat=%0d data=%h hit=%b",
                 addrs[k], cycles, resp_data1, resp_hit1, exp_lat[k], {17'd0, addrs[k]}, exp_hit[k]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_cold_and_spatial();
    test_conflict();
    test_reset_mid_miss();
    test_back_to_back();
    test_random();
    test_miss_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
